// File: rtl/bist_fail_logger.sv
// Failure logger for the memory BIST: counts failures per run and buffers records in a
// show-ahead FIFO that a host drains after done. Optional macro LOG_WRAP_EN keeps the newest
// records on overflow instead of the oldest.
module bist_fail_logger #(
  parameter int unsigned data_width = 4,
  parameter int unsigned ad_width   = 4,
  parameter int unsigned log_depth  = 4,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fail,
  input  logic [ad_width-1:0]   fail_addr,
  input  logic [data_width-1:0] fail_exp,
  input  logic [data_width-1:0] fail_act,
  input  logic                  done,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [ad_width-1:0]   rd_addr,
  output logic [data_width-1:0] rd_exp,
  output logic [data_width-1:0] rd_act,
  output logic [cnt_width-1:0]  err_cnt,
  output logic                  overflow,
  output logic                  pass,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(log_depth);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [cnt_width-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StReport} state_e;

  state_e                state_q, state_d;
  logic                  start_q;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0]  err_cnt_q, err_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  pass_q, pass_d;

  logic [ad_width-1:0]   addr_mem_q [log_depth];
  logic [data_width-1:0] exp_mem_q  [log_depth];
  logic [data_width-1:0] act_mem_q  [log_depth];

  logic                  start_rise;
  logic                  push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [IdxW-1:0]       wr_idx;
  logic [IdxW-1:0]       rd_idx;

  assign start_rise = start & ~start_q;
  assign wr_idx     = wr_ptr_q[IdxW-1:0];
  assign rd_idx     = rd_ptr_q[IdxW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // Same slot index but opposite wrap bit means the writer is one lap ahead.
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    pass_d     = pass_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StRun: begin
        if (fail) begin
          if (err_cnt_q != CntMax) begin
            err_cnt_d = err_cnt_q + cnt_width'(1);
          end
          if (!fifo_full) begin
            push     = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end else begin
            overflow_d = 1'b1;
`ifdef LOG_WRAP_EN
            // Overwrite the oldest slot and drag the head along with it.
            push     = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            rd_ptr_d = rd_ptr_q + PtrW'(1);
`endif
          end
        end
        if (done) begin
          state_d = StReport;
          pass_d  = (err_cnt_q == '0) && !fail;
        end
      end
      StReport: begin
        if (rd_en && !fifo_empty) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A start rise wins over everything, including a coincident fail.
    if (start_rise) begin
      state_d    = StRun;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      err_cnt_d  = '0;
      overflow_d = 1'b0;
      pass_d     = 1'b0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
      pass_q     <= pass_d;
    end
  end

  // Storage is reset so the show-ahead data outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < log_depth; i++) begin
        addr_mem_q[i] <= '0;
        exp_mem_q[i]  <= '0;
        act_mem_q[i]  <= '0;
      end
    end else if (push) begin
      addr_mem_q[wr_idx] <= fail_addr;
      exp_mem_q[wr_idx]  <= fail_exp;
      act_mem_q[wr_idx]  <= fail_act;
    end
  end

  assign rd_valid = (state_q == StReport) && !fifo_empty;
  assign rd_addr  = addr_mem_q[rd_idx];
  assign rd_exp   = exp_mem_q[rd_idx];
  assign rd_act   = act_mem_q[rd_idx];
  assign err_cnt  = err_cnt_q;
  assign overflow = overflow_q;
  assign pass     = pass_q;
  assign busy     = (state_q == StRun);

endmodule

// File: doc/bist_fail_logger.md
Name: bist_fail_logger

Overview:
- Sits directly downstream of the memory BIST top. Shares its clk, rst and start; consumes its per-cycle fail strobe, the failing address and expected/actual data, and done.
- Counts failures during a BIST run and buffers the first log_depth failure records in a show-ahead FIFO.
- After done, presents a pass/fail summary and lets a host drain the failure records through a valid/ready-style read port.

Parameters:
- data_width, 4, width of the expected/actual data words (matches the BIST top)
- ad_width, 4, width of the failing address (matches the BIST top)
- log_depth, 4, number of FIFO entries; must be a power of 2, ≥2
- cnt_width, 8, width of the failure counter

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  BIST start level, same signal that drives the BIST top
- fail  input  1  one-cycle failure strobe from the BIST; each high cycle is one failure event
- fail_addr  input  ad_width  address of the failing location, valid when fail=1
- fail_exp  input  data_width  expected data, valid when fail=1
- fail_act  input  data_width  data read back, valid when fail=1
- done  input  1  BIST completion
- rd_en  input  1  host pops the head record
- rd_valid  output  1  head record available
- rd_addr  output  ad_width  head record address
- rd_exp  output  data_width  head record expected data
- rd_act  output  data_width  head record actual data
- err_cnt  output  cnt_width  failures seen in the current/last run, saturating
- overflow  output  1  more failures occurred than log_depth
- pass  output  1  last run completed with zero failures
- busy  output  1  run in progress

Behaviour:
- Async reset (rst=0):
  - state=IDLE; FIFO empty; all outputs 0, including rd_* data.
  - start_q=0.
- start_rise = start & ~start_q; start_q is registered every cycle. A start held high for several cycles gives exactly one rise.
- States:
  - IDLE: start_rise → RUN.
  - RUN: busy=1.
    - start_rise → RUN (restart).
    - done=1 → REPORT.
  - REPORT: busy=0.
    - start_rise → RUN.
- Entering RUN from any state (on the start_rise edge):
  - FIFO pointers cleared; err_cnt=0; overflow=0; pass=0.
  - Any fail asserted in the same cycle as start_rise is ignored.
- In RUN, on each cycle with fail=1:
  - err_cnt increments, saturating at 2^cnt_width−1. New value visible the next cycle.
  - FIFO not full: push {fail_addr, fail_exp, fail_act}.
  - FIFO full: overflow set and held until the next RUN entry; record handled per the optional feature.
- fail=1 and done=1 in the same RUN cycle: the failure is counted and logged, then the state moves to REPORT. pass is computed including that failure.
- On the RUN→REPORT transition, pass = 1 only if no failure was counted in the run.
- fail and done are ignored outside RUN.
- Read port:
  - rd_valid = (state==REPORT) & FIFO not empty; forced 0 in IDLE and RUN.
  - rd_addr/rd_exp/rd_act always reflect the head entry (show-ahead, no read latency).
  - rd_en & rd_valid pops; the next entry is visible the following cycle.
  - rd_en with rd_valid=0 has no effect; no underflow.
- FIFO: read/write pointers are log2(log_depth)+1 bits, wrapping modulo 2·log_depth. full/empty derive from the MSB comparison. No push and pop occur in the same cycle, because they are state-exclusive.
- Reset mid-run: everything returns to the reset values immediately; the log is lost.
- err_cnt, overflow and pass hold their values in REPORT and IDLE until the next RUN entry.

Optional Feature:
- Macro LOG_WRAP_EN.
- Defined: when the FIFO is full, a new failure overwrites the oldest entry (read pointer advances with the write), so the log keeps the most recent log_depth failures. overflow is still set.
- Not defined: when full, new failure records are dropped, so the log keeps the first log_depth failures. err_cnt counts in both cases.

Test Plan:
- Clean run: reset 2 cycles; start high 2 cycles; done after 20 cycles with fail never high → pass=1, err_cnt=0, rd_valid=0, busy=0 in REPORT.
- Two failures: fail at addr 3 (exp 4'hA, act 4'h2) and addr 9 (exp 4'h5, act 4'h7), then done → err_cnt=2, pass=0, overflow=0. First read shows addr 3; after one rd_en pop it shows addr 9; after a second pop rd_valid=0.
- Overflow: 6 failures on addrs 0..5 with log_depth=4 → err_cnt=6, overflow=1.
  - Without LOG_WRAP_EN: reads return addrs 0,1,2,3.
  - With LOG_WRAP_EN: reads return addrs 2,3,4,5.
- Fail coincident with done: the only failure (addr 15) arrives in the same cycle as done → err_cnt=1, pass=0, one record with addr 15.
- Restart and reset:
  - From REPORT with 2 logged records, a second start → rd_valid=0, err_cnt=0, busy=1 on the next cycle.
  - rst pulled low mid-RUN → all outputs 0 asynchronously; start rise after release re-enters RUN.
